// File: rtl/msrv32_machine_csr_file.sv
// Machine-mode CSR file: trap/return bookkeeping, interrupt enable/pending state,
// 64-bit cycle/instret counters and Zicsr read/modify/write access.
module msrv32_machine_csr_file #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE   = 32'h4000_0100
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        ms_riscv32_mp_eirq_in,
    input  logic        ms_riscv32_mp_tirq_in,
    input  logic        ms_riscv32_mp_sirq_in,
    input  logic        set_epc_in,
    input  logic        set_cause_in,
    input  logic [3:0]  cause_in,
    input  logic        i_or_e_in,
    input  logic        misaligned_exception_in,
    input  logic        mie_clear_in,
    input  logic        mie_set_in,
    input  logic        instret_inc_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iadder_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic        csr_wr_en_in,
    input  logic [31:0] rs1_in,
    input  logic [4:0]  imm_in,
    output logic [31:0] csr_data_out,
    output logic        illegal_csr_out,
    output logic        mie_out,
    output logic        meie_out,
    output logic        mtie_out,
    output logic        msie_out,
    output logic        meip_out,
    output logic        mtip_out,
    output logic        msip_out,
    output logic [31:0] trap_address_out,
    output logic [31:0] epc_out
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_reg_q, mie_reg_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [2:0]  mip_q, mip_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] csr_rdata;
    logic        addr_valid;
    logic [31:0] operand;
    logic [31:0] wr_val;
    logic        csr_write;
    logic [31:0] trap_base;

    always_comb begin
        csr_rdata  = 32'h0;
        addr_valid = 1'b1;
        case (csr_addr_in)
            12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            12'h301: csr_rdata = MISA_VALUE;
            12'h304: csr_rdata = mie_reg_q;
            12'h305: csr_rdata = mtvec_q;
            12'h340: csr_rdata = mscratch_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h344: csr_rdata = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
            12'hB00: csr_rdata = mcycle_q[31:0];
            12'hB80: csr_rdata = mcycle_q[63:32];
            12'hB02: csr_rdata = minstret_q[31:0];
            12'hB82: csr_rdata = minstret_q[63:32];
            12'hF11, 12'hF12, 12'hF13, 12'hF14: csr_rdata = 32'h0;
            default: addr_valid = 1'b0;
        endcase
    end

    assign illegal_csr_out = csr_wr_en_in && (!addr_valid || (csr_addr_in[11:10] == 2'b11));
    assign operand         = csr_op_in[2] ? {27'b0, imm_in} : rs1_in;
    assign csr_write       = csr_wr_en_in && !illegal_csr_out && (csr_op_in[1:0] != 2'b00);

    always_comb begin
        case (csr_op_in[1:0])
            2'b01:   wr_val = operand;
            2'b10:   wr_val = csr_rdata | operand;
            2'b11:   wr_val = csr_rdata & ~operand;
            default: wr_val = csr_rdata;
        endcase
    end

    // CSR writes are applied first so trap and mret strobes can override them.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_reg_d      = mie_reg_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mip_d          = {ms_riscv32_mp_eirq_in, ms_riscv32_mp_tirq_in, ms_riscv32_mp_sirq_in};
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'b0, instret_inc_in};

        if (csr_write) begin
            case (csr_addr_in)
                12'h300: begin
                    mstatus_mie_d  = wr_val[3];
                    mstatus_mpie_d = wr_val[7];
                end
                12'h304: mie_reg_d  = wr_val & 32'h0000_0888;
                12'h305: mtvec_d    = wr_val & 32'hFFFF_FFFD;
                12'h340: mscratch_d = wr_val;
                12'h341: mepc_d     = wr_val & 32'hFFFF_FFFC;
                12'h342: mcause_d   = wr_val & 32'h8000_000F;
                12'h343: mtval_d    = wr_val;
                12'hB00: mcycle_d   = {mcycle_q[63:32], wr_val};
                12'hB80: mcycle_d   = {wr_val, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], wr_val};
                12'hB82: minstret_d = {wr_val, minstret_q[31:0]};
                default: ;
            endcase
        end

        if (mie_clear_in) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mie_set_in) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        if (set_epc_in) begin
            mepc_d = pc_in & 32'hFFFF_FFFC;
        end
        if (set_cause_in) begin
            mcause_d = {i_or_e_in, 27'b0, cause_in};
            mtval_d  = misaligned_exception_in ? iadder_in : 32'h0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_reg_q      <= 32'h0;
            mtvec_q        <= RESET_VECTOR & 32'hFFFF_FFFC;
            mscratch_q     <= 32'h0;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            mip_q          <= 3'b0;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_reg_q      <= mie_reg_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mip_q          <= mip_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    // Vectored mode offsets only interrupts; exceptions always go to BASE.
    assign trap_base        = {mtvec_q[31:2], 2'b00};
    assign trap_address_out = (mtvec_q[0] && i_or_e_in) ? trap_base + {26'b0, cause_in, 2'b00}
                                                        : trap_base;

    assign csr_data_out = csr_rdata;
    assign epc_out      = mepc_q;
    assign mie_out      = mstatus_mie_q;
    assign meie_out     = mie_reg_q[11];
    assign mtie_out     = mie_reg_q[7];
    assign msie_out     = mie_reg_q[3];
    assign meip_out     = mip_q[2];
    assign mtip_out     = mip_q[1];
    assign msip_out     = mip_q[0];

endmodule

// File: doc/msrv32_machine_csr_file.md
Name: msrv32_machine_csr_file

Overview:
- Machine-mode CSR register file that consumes the trap and retire control strobes from the machine control unit.
- Holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcycle and minstret.
- Returns interrupt enable/pending state, the trap vector address and the return PC.
- Also services Zicsr reads and writes issued in the writeback stage.

Parameters:
- RESET_VECTOR, 32'h0000_0000, reset value of mtvec BASE.
- MISA_VALUE, 32'h4000_0100, read-only misa content (RV32I).

Ports:
- ms_riscv32_mp_clk_in  in  1  clock.
- ms_riscv32_mp_rst_in  in  1  asynchronous, active-high reset.
- ms_riscv32_mp_eirq_in / ms_riscv32_mp_tirq_in / ms_riscv32_mp_sirq_in  in  1 each  raw external, timer and software interrupt lines.
- set_epc_in, set_cause_in  in  1 each  trap strobes.
- cause_in  in  4  trap cause code.
- i_or_e_in  in  1  1 = interrupt, 0 = exception.
- misaligned_exception_in  in  1  misaligned instruction trap; write mtval.
- mie_clear_in  in  1  trap entry, stack MIE.
- mie_set_in  in  1  mret, unstack MIE.
- instret_inc_in  in  1  retire strobe.
- pc_in  in  32  PC of the trapping instruction.
- iadder_in  in  32  faulting target address.
- csr_addr_in  in  12  CSR address.
- csr_op_in  in  3  funct3.
- csr_wr_en_in  in  1  CSR write request.
- rs1_in  in  32  register operand.
- imm_in  in  5  zimm operand.
- csr_data_out  out  32  read data.
- illegal_csr_out  out  1  illegal CSR access.
- mie_out, meie_out, mtie_out, msie_out, meip_out, mtip_out, msip_out  out  1 each  status/enable/pending bits.
- trap_address_out  out  32  next PC on trap.
- epc_out  out  32  mepc value, used by mret.

Behaviour:
- Reset (async) clears every register except:
  - mtvec = {RESET_VECTOR[31:2], 2'b00}.
  - mstatus.MPP reads 2'b11 (hardwired).
  - All outputs therefore read 0 except trap_address_out = RESET_VECTOR.
- Map:
  - 0x300 mstatus: MIE bit 3, MPIE bit 7, MPP [12:11] = 11, others 0.
  - 0x301 misa: read-only.
  - 0x304 mie: bits 11/7/3 writable, others 0.
  - 0x305 mtvec: MODE bit 0 writable, bit 1 = 0.
  - 0x340 mscratch.
  - 0x341 mepc: [1:0] = 0.
  - 0x342 mcause: bit 31 plus [3:0].
  - 0x343 mtval.
  - 0x344 mip: read-only, bits 11/7/3.
  - 0xB00 / 0xB80 mcycle lo/hi; 0xB02 / 0xB82 minstret lo/hi.
  - 0xF11–0xF14: read 0.
  - Any other address reads 0.
- Read: csr_data_out is combinational from csr_addr_in, reflecting register state before any same-cycle write.
- Write value, registered on the clock edge when csr_wr_en_in = 1:
  - Operand = rs1_in if funct3[2] = 0, else {27'b0, imm_in}.
  - funct3[1:0]: 01 = write, 10 = old | operand, 11 = old & ~operand; 00 = no write.
  - Result is masked by per-register writable bits.
- illegal_csr_out (combinational) = 1 when:
  - csr_wr_en_in = 1 and the address is unimplemented, or
  - csr_wr_en_in = 1 and csr_addr_in[11:10] = 11 (read-only space).
  - The write is suppressed in both cases.
- Interrupt sync: eirq/tirq/sirq are registered once into mip; meip/mtip/msip_out lag the inputs by 1 cycle.
- Trap entry (set_epc_in / set_cause_in):
  - mepc <= {pc_in[31:2], 2'b00}.
  - mcause <= {i_or_e_in, 27'b0, cause_in}.
  - mtval <= iadder_in if misaligned_exception_in, else 0.
- trap_address_out (combinational):
  - mtvec MODE = 0, or i_or_e_in = 0: {BASE, 2'b00}.
  - Otherwise: {BASE, 2'b00} + (cause_in << 2).
- mie_clear_in: MPIE <= MIE, MIE <= 0.
- mie_set_in: MIE <= MPIE, MPIE <= 1.
- Both strobes together: clear wins.
- Same-cycle CSR write and trap/mie strobe to the same register: the trap/strobe update wins; the CSR write to that register is dropped.
- Counters (64-bit):
  - mcycle increments every cycle; minstret increments when instret_inc_in = 1.
  - Both wrap 2^64-1 -> 0.
  - A CSR write to either half replaces that half and suppresses that counter's increment in that cycle.
  - The low-half carry into the high half is computed on the old value.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight writes are lost.

Test Plan:
- Reset -> csr_data_out @0x300 = 32'h0000_1800; @0x305 = RESET_VECTOR; mcycle counts 1, 2, 3 on the following edges.
- CSRRW 0x304 with rs1 = 32'hFFFF_FFFF, then read -> 32'h0000_0888; CSRRC with imm = 5'h08 -> 32'h0000_0880.
- mtvec = 32'h0000_1001, i_or_e_in = 1, cause_in = 7 -> trap_address_out = 32'h0000_101C; with i_or_e_in = 0 -> 32'h0000_1000.
- set_epc/set_cause with pc_in = 32'h0000_0206, cause 0, misaligned = 1, iadder = 32'h0000_0305 -> mepc = 32'h0000_0204, mcause = 0, mtval = 32'h0000_0305.
- MIE = 1 then mie_clear -> mstatus = 32'h0000_1880; mie_set next -> 32'h0000_1888; clear and set together -> MIE = 0.
- minstret = 64'h0000_0000_FFFF_FFFF + instret_inc -> 64'h0000_0001_0000_0000; write to 0xF14 -> illegal_csr_out = 1, no state change.
